// File: rtl/frame_controller.sv
`default_nettype none
// frame_controller: frame-slot timer with buffer-switch pulses, render FSM
// and per-frame pixel / frame / dropped-switch statistics.
module frame_controller #(
   parameter int FRAME_PERIOD = 2000000,
   parameter int TIMER_WIDTH  = 22,
   parameter int COUNT_WIDTH  = 16,
   parameter int NUM_BUFFERS  = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           mode_in,
   input  logic                           framebuffer_ready_in,
   input  logic                           pixel_valid_in,
   input  logic                           frame_done_in,
   output logic                           fetch_rst_out,
   output logic                           switch_out,
   output logic                           clear_out,
   output logic [$clog2(NUM_BUFFERS)-1:0] buffer_index_out,
   output logic [COUNT_WIDTH-1:0]         pixel_count_out,
   output logic [COUNT_WIDTH-1:0]         last_pixel_count_out,
   output logic [COUNT_WIDTH-1:0]         frame_count_out,
   output logic [COUNT_WIDTH-1:0]         dropped_count_out,
   output logic [1:0]                     state_out
);

   localparam int                      IDX_WIDTH  = $clog2(NUM_BUFFERS);
   localparam logic [TIMER_WIDTH-1:0]  TIMER_MAX  = TIMER_WIDTH'(FRAME_PERIOD - 1);
   localparam logic [COUNT_WIDTH-1:0]  COUNT_MAX  = '1;
   localparam logic [IDX_WIDTH-1:0]    LAST_INDEX = IDX_WIDTH'(NUM_BUFFERS - 1);

   typedef enum logic [1:0] {
      WAIT_BUFFER = 2'd0,
      START       = 2'd1,
      RENDER      = 2'd2,
      DONE        = 2'd3
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic                   next_fetch_rst;
   logic                   ready_drop;
   logic                   timer_at_max;
   logic                   fire;
   logic [COUNT_WIDTH-1:0] pixel_next;
   logic [TIMER_WIDTH-1:0] timer;

   always_comb begin
      next_state     = state;
      next_fetch_rst = fetch_rst_out;
      ready_drop     = 1'b0;
      timer_at_max   = (timer == TIMER_MAX);
      // In render-driven mode the slot end waits until the frame is drained.
      fire           = timer_at_max && (!mode_in || (state == DONE));
      pixel_next     = pixel_count_out;
      if (pixel_valid_in && ((state == RENDER) || (state == DONE)) &&
          (pixel_count_out != COUNT_MAX))
         pixel_next = pixel_count_out + 1'b1;

      case (state)
         WAIT_BUFFER: begin
            if (framebuffer_ready_in) begin
               next_state     = START;
               next_fetch_rst = 1'b0;
            end
         end
         START: next_state = RENDER;
         RENDER, DONE: begin
            // Losing the framebuffer outranks frame completion in the same cycle.
            if (!framebuffer_ready_in) begin
               next_state     = WAIT_BUFFER;
               next_fetch_rst = 1'b1;
               ready_drop     = 1'b1;
            end else if ((state == RENDER) && frame_done_in) begin
               next_state = DONE;
            end
         end
         default: next_state = WAIT_BUFFER;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state         <= WAIT_BUFFER;
         fetch_rst_out <= 1'b1;
      end else begin
         state         <= next_state;
         fetch_rst_out <= next_fetch_rst;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         timer                <= '0;
         switch_out           <= 1'b0;
         clear_out            <= 1'b0;
         buffer_index_out     <= '0;
         pixel_count_out      <= '0;
         last_pixel_count_out <= '0;
         frame_count_out      <= '0;
         dropped_count_out    <= '0;
      end else begin
         switch_out <= fire;
         clear_out  <= fire;
         if (fire) begin
            timer            <= '0;
            buffer_index_out <= (buffer_index_out == LAST_INDEX) ? '0 : buffer_index_out + 1'b1;
            if ((state == RENDER) && (dropped_count_out != COUNT_MAX))
               dropped_count_out <= dropped_count_out + 1'b1;
         end else if (!timer_at_max) begin
            timer <= timer + 1'b1;
         end

         if (state == START) begin
            pixel_count_out <= '0;
            frame_count_out <= frame_count_out + 1'b1;
         end else begin
            pixel_count_out <= pixel_next;
         end

         if (ready_drop)
            last_pixel_count_out <= pixel_next;
      end
   end

   assign state_out = state;

endmodule
`default_nettype wire

// File: tb/tb_frame_controller.sv
`default_nettype none
// tb_frame_controller: vector table, directed corner sequences and random
// stimulus checked against an event-counting behavioural model.
module tb_frame_controller;

   localparam int FP   = 8;
   localparam int TW   = 3;
   localparam int CW   = 4;
   localparam int NB   = 3;
   localparam int CMAX = 15;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          mode  = 1'b0;
   logic          ready = 1'b0;
   logic          valid = 1'b0;
   logic          done  = 1'b0;
   logic          fetch_rst, sw, clr;
   logic [1:0]    bidx;
   logic [CW-1:0] pix, last, frames, dropped;
   logic [1:0]    st;

   always #5 clk = ~clk;

   frame_controller #(
      .FRAME_PERIOD(FP),
      .TIMER_WIDTH (TW),
      .COUNT_WIDTH (CW),
      .NUM_BUFFERS (NB)
   ) dut (
      .clk_in              (clk),
      .rst_in              (rst_n),
      .mode_in             (mode),
      .framebuffer_ready_in(ready),
      .pixel_valid_in      (valid),
      .frame_done_in       (done),
      .fetch_rst_out       (fetch_rst),
      .switch_out          (sw),
      .clear_out           (clr),
      .buffer_index_out    (bidx),
      .pixel_count_out     (pix),
      .last_pixel_count_out(last),
      .frame_count_out     (frames),
      .dropped_count_out   (dropped),
      .state_out           (st)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0..3 = waiting, start, render, done; counters are raw event
   // totals, turned into output values by modulo / saturation at compare time.
   int m_phase, m_timer, m_pulses, m_frames, m_dropped, m_pix, m_last;
   int m_fetch, m_sw;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_timer = 0; m_pulses = 0; m_frames = 0;
      m_dropped = 0; m_pix = 0; m_last = 0; m_fetch = 1; m_sw = 0;
   endfunction

   function automatic void model_step();
      int fire;
      fire = (m_timer == FP - 1) && (mode == 1'b0 || m_phase == 3);
      m_sw = fire;
      if (fire != 0) begin
         m_pulses++;
         if (m_phase == 2) m_dropped++;
         m_timer = 0;
      end else if (m_timer < FP - 1) begin
         m_timer++;
      end
      if (m_phase == 0) begin
         if (ready) begin m_fetch = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
         m_pix = 0; m_frames++; m_phase = 2;
      end else begin
         if (valid) m_pix++;
         if (!ready) begin
            m_last = m_pix; m_fetch = 1; m_phase = 0;
         end else if (m_phase == 2 && done) begin
            m_phase = 3;
         end
      end
   endfunction

   task automatic model_check();
      check("state", st, m_phase);
      check("fetch_rst", fetch_rst, m_fetch);
      check("switch", sw, m_sw);
      check("clear", clr, m_sw);
      check("buffer_index", bidx, m_pulses % NB);
      check("pixel_count", pix, sat(m_pix));
      check("last_pixel_count", last, sat(m_last));
      check("frame_count", frames, m_frames % (CMAX + 1));
      check("dropped_count", dropped, sat(m_dropped));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; mode = 1'b0; ready = 1'b0; valid = 1'b0; done = 1'b0;
      #2;
      model_reset();
      model_check();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic r, v, d;
      int   st, fetch, pix, last, frames;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 2, 0, 0, 0, 1};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 2, 0, 1, 0, 1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 2, 0, 2, 0, 1};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 2, 0, 3, 0, 1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 2, 0, 4, 0, 1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 2, 0, 5, 0, 1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 0, 1, 5, 5, 1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 0, 1, 5, 5, 1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 0, 5, 5, 1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 5, 2};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 3, 0, 1, 5, 2};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 0, 1, 2, 2, 2};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1, 0, 2, 2, 2};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 2, 3};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 0, 1, 1, 1, 3};

      // Frame handshake and ready-drop priority, from the vector table.
      do_reset();
      mode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ready = vecs[i].r; valid = vecs[i].v; done = vecs[i].d;
         tick();
         check($sformatf("vec%0d_state", i), st, vecs[i].st);
         check($sformatf("vec%0d_fetch", i), fetch_rst, vecs[i].fetch);
         check($sformatf("vec%0d_pix", i), pix, vecs[i].pix);
         check($sformatf("vec%0d_last", i), last, vecs[i].last);
         check($sformatf("vec%0d_frames", i), frames, vecs[i].frames);
      end

      // Fixed-period switching while rendering: pulses every 8 edges, all dropped.
      do_reset();
      ready = 1'b1; valid = 1'b0; done = 1'b0;
      for (int k = 0; k < 32; k++) begin
         tick();
         check($sformatf("t0_pulse_k%0d", k), sw, (k % 8 == 7) ? 1 : 0);
         check($sformatf("t0_bidx_k%0d", k), bidx, ((k + 1) / 8) % NB);
         check($sformatf("t0_dropped_k%0d", k), dropped, (k + 1) / 8);
      end

      // Render-driven mode: no pulse until the frame is done.
      do_reset();
      mode = 1'b1; ready = 1'b1;
      for (int k = 0; k < 31; k++) begin
         done = (k == 20);
         tick();
         check($sformatf("t1_pulse_k%0d", k), sw, (k == 21 || k == 29) ? 1 : 0);
         check($sformatf("t1_state_k%0d", k), st, (k == 0) ? 1 : ((k < 20) ? 2 : 3));
         check($sformatf("t1_dropped_k%0d", k), dropped, 0);
      end
      done = 1'b0;

      // Pixel counter saturation.
      do_reset();
      mode = 1'b1; ready = 1'b1;
      tick(); tick();
      valid = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      check("sat_pix", pix, 15);
      valid = 1'b0; ready = 1'b0;
      tick();
      check("sat_last", last, 15);
      check("sat_state", st, 0);

      // Asynchronous reset mid-render with nine pixels counted.
      do_reset();
      ready = 1'b1;
      tick(); tick();
      valid = 1'b1;
      for (int k = 0; k < 9; k++) tick();
      valid = 1'b0;
      check("pre_reset_pix", pix, 9);
      #2 rst_n = 1'b0;
      #1;
      check("areset_fetch", fetch_rst, 1);
      check("areset_switch", sw, 0);
      check("areset_clear", clr, 0);
      check("areset_bidx", bidx, 0);
      check("areset_pix", pix, 0);
      check("areset_last", last, 0);
      check("areset_frames", frames, 0);
      check("areset_dropped", dropped, 0);
      check("areset_state", st, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model, including mode flips and resets.
      mode = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         ready = ($urandom_range(0, 15) != 0);
         valid = $urandom_range(0, 1) == 1;
         done  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            model_check();
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/frame_controller.md
FRAME_CONTROLLER -- requirements
Module: frame_controller

Interface
REQ-001 The module SHALL have parameter FRAME_PERIOD, default 2000000: cycles per frame slot; minimum legal value 4.
REQ-002 The module SHALL have parameter TIMER_WIDTH, default 22: frame timer width; must hold FRAME_PERIOD-1.
REQ-003 The module SHALL have parameter COUNT_WIDTH, default 16: width of the pixel, frame and dropped counters.
REQ-004 The module SHALL have parameter NUM_BUFFERS, default 2: number of framebuffers; legal values 2..4.
REQ-005 The module SHALL have these ports, clock and reset first:
- clk_in  input  1  sole clock, all logic on rising edge.
- rst_in  input  1  reset, asynchronous and active-low.
- mode_in  input  1  0 = timer mode (fixed switch), 1 = render-driven mode.
- framebuffer_ready_in  input  1  framebuffer accepting pixels.
- pixel_valid_in  input  1  one pixel written this cycle.
- frame_done_in  input  1  pipeline drained for current frame.
- fetch_rst_out  output  1  holds vertex fetch in reset.
- switch_out  output  1  one-cycle buffer-switch pulse.
- clear_out  output  1  one-cycle clear pulse, identical to switch_out.
- buffer_index_out  output  $clog2(NUM_BUFFERS)  current back-buffer index.
- pixel_count_out  output  COUNT_WIDTH  pixels in current frame.
- last_pixel_count_out  output  COUNT_WIDTH  pixel count of last completed or aborted frame.
- frame_count_out  output  COUNT_WIDTH  frames started.
- dropped_count_out  output  COUNT_WIDTH  switches taken mid-render.
- state_out  output  2  encoded FSM state: WAIT_BUFFER=0, START=1, RENDER=2, DONE=3.

Function
REQ-006 The FSM SHALL have states WAIT_BUFFER, START, RENDER and DONE.
REQ-007 In WAIT_BUFFER, when framebuffer_ready_in=1 the FSM SHALL clear fetch_rst_out and enter START on the next edge.
REQ-008 START SHALL last exactly one cycle: pixel_count<=0, frame_count+1 (wraps), then enter RENDER.
REQ-009 In RENDER and DONE, each cycle with pixel_valid_in=1 SHALL increment pixel_count, saturating at all-ones.
REQ-010 In RENDER, frame_done_in=1 SHALL move the FSM to DONE.
REQ-011 In RENDER or DONE, framebuffer_ready_in=0 SHALL move the FSM to WAIT_BUFFER, set fetch_rst_out=1, and latch last_pixel_count, including any pixel counted that cycle.
REQ-012 When framebuffer_ready_in=0 and frame_done_in=1 in the same cycle, ready deassertion SHALL win and the FSM SHALL go to WAIT_BUFFER.
REQ-013 The timer SHALL count every cycle from 0.
REQ-014 In mode 0, at timer=FRAME_PERIOD-1 the module SHALL pulse switch_out and clear_out for one cycle and reset the timer to 0, giving a period of exactly FRAME_PERIOD cycles.
REQ-015 In mode 1, the timer SHALL saturate at FRAME_PERIOD-1.
REQ-016 In mode 1, a pulse SHALL fire on the first cycle with timer=FRAME_PERIOD-1 and the state registered as DONE, then the timer SHALL reset to 0.
REQ-017 A pulse issued while the state is RENDER SHALL increment dropped_count, saturating; this case is possible only in mode 0.
REQ-018 Each pulse SHALL advance buffer_index_out by 1, modulo NUM_BUFFERS, in the same cycle switch_out is high.
REQ-019 mode_in SHALL be sampled every cycle with immediate effect; a mode change SHALL NOT reset the timer or the FSM.
REQ-020 Pulses SHALL be generated regardless of FSM state, subject to REQ-016 in mode 1.
REQ-021 All outputs SHALL be registered; no combinational input-to-output path is permitted.

Reset
REQ-022 rst_in=0 SHALL asynchronously force: fetch_rst_out=1; switch_out=0; clear_out=0; buffer_index_out=0; all counters 0; timer 0; state WAIT_BUFFER.
REQ-023 A reset assertion mid-frame SHALL abort the frame without latching last_pixel_count.
REQ-024 After reset release, operation SHALL resume on the first rising edge with rst_in=1.

Verification
REQ-025 Mode 0, FRAME_PERIOD=8, framebuffer_ready_in=1 after reset -> pulses at cycles 7, 15, 23 after release; buffer_index_out sequence 0,1,0,1.
REQ-026 Hold ready, 5 pixel_valid pulses, then drop ready -> last_pixel_count_out=5, fetch_rst_out=1 next cycle, state_out=0; reassert ready -> START one cycle, frame_count_out increments by 1.
REQ-027 Mode 1, FRAME_PERIOD=8, frame_done_in at cycle 20 -> no pulse before DONE; pulse on the cycle after state_out=3; dropped_count_out stays 0.
REQ-028 Mode 0, no frame_done_in, pulse while in RENDER -> dropped_count_out=1; NUM_BUFFERS=3 over 4 pulses -> buffer_index_out sequence 0,1,2,0,1.
REQ-029 Same-cycle ready drop, frame_done_in and pixel_valid_in -> WAIT_BUFFER, count includes the pixel.
REQ-030 Async reset mid-RENDER with pixel_count=9 -> all outputs at reset values before the next edge.
REQ-031 COUNT_WIDTH=4 with 20 pixels in one frame -> pixel_count_out saturates at 15.
